// File: rtl/team_wb_master_pkg.sv
// rtl/team_wb_master_pkg.sv - shared types and constants for the Wishbone initiator
package team_wb_master_pkg;

  localparam int WB_DW          = 32;
  localparam int WB_AW          = 32;
  localparam int WB_BYTE_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    STROBE = 3'd2,
    DONE   = 3'd3,
    ABORT  = 3'd4
  } state_e;

  // Incrementing burst: adding a multiple of the stride leaves the low lane bits intact
  function automatic logic [WB_AW-1:0] next_beat_adr(input logic [WB_AW-1:0] adr);
    return adr + WB_AW'(WB_BYTE_STRIDE);
  endfunction

endpackage

// File: rtl/team_wb_timeout.sv
// rtl/team_wb_timeout.sv - per-beat acknowledge watchdog counter
module team_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // cnt_q holds the strobe cycles already spent, so the last allowed cycle sees TIMEOUT_CYCLES-1
  assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/team_wb_master.sv
// rtl/team_wb_master.sv - Wishbone classic initiator with burst and ack timeout
module team_wb_master
  import team_wb_master_pkg::*;
#(
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [WB_AW-1:0] req_adr_i,
  input  logic [3:0]       req_sel_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [WB_DW-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [WB_DW-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o,
  output logic [WB_AW-1:0] ADR_O,
  output logic [WB_DW-1:0] DAT_O,
  output logic [3:0]       SEL_O,
  output logic             WE_O,
  output logic             STB_O,
  output logic             CYC_O,
  input  logic [WB_DW-1:0] DAT_I,
  input  logic             ACK_I
);

  state_e             state_q, state_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               stb_q, stb_d;
  logic               cyc_q, cyc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [WB_DW-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               wr_ready_q, wr_ready_d;

  logic               ack_seen;
  logic               to_expired;

  assign ack_seen = ACK_I && stb_q;

  team_wb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     ((state_q != STROBE) || ack_seen),
    .en_i      (state_q == STROBE),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          adr_d  = req_adr_i;
          sel_d  = req_sel_i;
          we_d   = req_we_i;
          len_d  = req_len_i;
          beat_d = '0;
          cyc_d  = 1'b1;
          if (req_we_i) begin
            state_d = WDATA;
          end else begin
            stb_d   = 1'b1;
            state_d = STROBE;
          end
        end
      end
      WDATA: begin
        if (wr_valid_i) begin
          dat_d   = wr_data_i;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        // An ack on the final timeout cycle still completes the beat
        if (ack_seen) begin
          if (!we_q) begin
            rd_data_d  = DAT_I;
            rd_valid_d = 1'b1;
          end
          if (beat_q == len_q) begin
            stb_d   = 1'b0;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            state_d = DONE;
          end else begin
            adr_d  = next_beat_adr(adr_q);
            beat_d = beat_q + LEN_W'(1);
            if (we_q) begin
              stb_d   = 1'b0;
              state_d = WDATA;
            end
          end
        end else if (to_expired) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ABORT;
        end
      end
      DONE, ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered
    done_d      = (state_d == DONE) || (state_d == ABORT);
    err_d       = (state_d == ABORT);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WDATA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      cyc_q       <= cyc_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign SEL_O       = sel_q;
  assign WE_O        = we_q;
  assign STB_O       = stb_q;
  assign CYC_O       = cyc_q;

endmodule

// File: doc/team_wb_master.md
Name: team_wb_master

Overview:
- Wishbone classic (B3) initiator. It lets team logic issue single or incrementing-burst reads and writes onto the Nebula arbitrator master port (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I).
- Sits inside team_NN_WB beside the slave-side bus wrapper. It is the initiator counterpart of that slave path.
- Team-side interface is request/data valid-ready handshakes. A per-beat ACK timeout guards against a hung bus.

Parameters:
- LEN_W, 4, width of burst length field. Max burst is 2**LEN_W beats.
- TIMEOUT_CYCLES, 255, cycles with STB_O high and no ACK_I before the transaction is aborted. Must be ≥1.
- TO_W, 8, timeout counter width. Must satisfy TO_W ≥ clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  system clock (wb_clk_i)
- rst_i  in  1  synchronous reset, active-high (wb_rst_i)
- req_valid_i  in  1  transaction request
- req_ready_o  out  1  accepting request (IDLE only)
- req_we_i  in  1  1=write, 0=read
- req_adr_i  in  32  start byte address
- req_sel_i  in  4  byte lanes, held for all beats
- req_len_i  in  LEN_W  beats minus 1
- wr_data_i  in  32  write beat data
- wr_valid_i  in  1  write data available
- wr_ready_o  out  1  write beat accepted this cycle
- rd_data_o  out  32  read beat data
- rd_valid_o  out  1  one-cycle pulse per read beat, no backpressure
- done_o  out  1  one-cycle pulse at transaction end
- err_o  out  1  one-cycle pulse with done_o on timeout abort
- busy_o  out  1  state != IDLE
- ADR_O  out  32  Wishbone address
- DAT_O  out  32  Wishbone write data
- SEL_O  out  4  Wishbone byte select
- WE_O  out  1  Wishbone write enable
- STB_O  out  1  Wishbone strobe
- CYC_O  out  1  Wishbone cycle
- DAT_I  in  32  Wishbone read data
- ACK_I  in  1  Wishbone acknowledge

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, including req_ready_o and rd_data_o.
- Reset is honoured in any state. A mid-transaction reset drops CYC_O/STB_O at that edge with no done_o/err_o, and returns to IDLE.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch adr, sel, we and len, clear beat counter, set CYC_O=1.
  - Go to WDATA if write, otherwise go to STROBE with STB_O=1.
- State WDATA:
  - CYC_O=1, STB_O=0, wr_ready_o=1 combinationally from state.
  - On wr_valid_i: DAT_O←wr_data_i, STB_O←1, WE_O←1, go to STROBE.
  - CYC_O stays high while waiting for data.
- State STROBE:
  - STB_O=1. Timeout counter increments each cycle.
  - On ACK_I:
    - Read: rd_data_o←DAT_I, with rd_valid_o=1 the following cycle.
    - Timeout counter clears.
    - If beat==len: STB_O←0, CYC_O←0, go to DONE.
    - Otherwise: ADR_O←ADR_O+4 (mod 2^32, low 2 bits preserved), beat++.
      - Read: STB_O stays 1 (back-to-back, 1 beat/cycle max).
      - Write: STB_O←0, go to WDATA.
- Timeout: counter reaches TIMEOUT_CYCLES with no ACK_I → STB_O←0, CYC_O←0, remaining beats discarded, go to ABORT.
  - If ACK_I and timeout coincide, ACK wins.
- State DONE: done_o=1 for one cycle, then IDLE.
- State ABORT: done_o=1 and err_o=1 for one cycle, then IDLE.
- ACK_I is ignored when STB_O=0.
- DAT_I is sampled only on an ACK in a read STROBE.
- Request latency: req accepted at edge N → STB_O high at N+1 for reads. For writes, STB_O rises the cycle after wr_valid_i.
- Completion latency: last ACK at edge M → CYC_O low at M+1, done_o high at M+1.
- Burst length: len=0 is 1 beat, len=2**LEN_W-1 is the maximum.
- req_valid_i outside IDLE is ignored (req_ready_o=0).

Decomposition:
- Package team_wb_master_pkg:
  - state enum {IDLE, WDATA, STROBE, DONE, ABORT}
  - WB_BYTE_STRIDE=4
  - WB_DW=32, WB_AW=32
- Sub-module team_wb_timeout:
  - counter with clear/enable, output expired at TIMEOUT_CYCLES.
  - Synchronous active-high reset on rst_i.

Test Plan:
1. Single read:
   - Stimulus: req adr=0x3000_0010, sel=0xF, len=0. Slave ACKs 2 cycles after STB with DAT_I=0xDEADBEEF.
   - Response: ADR_O=0x3000_0010, WE_O=0, one rd_valid_o with 0xDEADBEEF, done_o=1, err_o=0, CYC_O low the cycle after ACK.
2. Write burst:
   - Stimulus: len=3, adr=0x3000_0000, data 0x11,0x22,0x33,0x44, wr_valid_i delayed 3 cycles before beat 2.
   - Response: ADR_O steps 0x00/0x04/0x08/0x0C with matching DAT_O, CYC_O high throughout, STB_O low during the wait, exactly 4 wr_ready_o handshakes, one done_o.
3. Read burst with zero-wait slave:
   - Stimulus: ACK_I same cycle as STB, len=15.
   - Response: 16 consecutive rd_valid_o pulses, STB_O continuously high for 16 cycles.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=8, slave never ACKs.
   - Response: STB_O/CYC_O drop after 8 strobe cycles, done_o and err_o pulse together, busy_o=0 next cycle.
   - Also: ACK on cycle 8 completes normally with err_o=0.
5. Address wrap:
   - Stimulus: adr=0xFFFF_FFFC, len=1 read.
   - Response: second beat ADR_O=0x0000_0000, SEL_O unchanged.
6. Reset and spurious inputs:
   - Stimulus: rst_i asserted mid-burst after beat 1 ACK.
   - Response: all outputs 0 next edge, no done_o, req_ready_o=1 after release. A spurious ACK_I while idle leaves rd_valid_o=0.
